// File: rtl/rhd_chip_responder.sv
`default_nettype none
// ============================================================================
// Module  : rhd_chip_responder
// Brief   : Runs config/record/zcheck jobs as 16-bit Intan SPI frames to one
//           headstage chip and returns captured MISO words as parallel data.
// Revision: 1.0 - initial release
// ============================================================================
module rhd_chip_responder #(
    parameter int CHANNELS       = 32,
    parameter int N_CFG          = 8,
    parameter int ZCHECK_SAMPLES = 4,
    parameter int CS_GAP         = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        config_start,
    input  logic                        record_start,
    input  logic                        zcheck_start,
    input  logic [11:0]                 zcheck_channel,
    input  logic [1:0]                  zcheck_scale,
    input  logic [N_CFG*8-1:0]          cfg_data,
    output logic                        busy,
    output logic                        done,
    output logic                        zcheck_error,
    output logic [CHANNELS*16-1:0]      data_out,
    output logic [ZCHECK_SAMPLES*16-1:0] zcheck_data_out,
    output logic [7:0]                  channel_out,
    output logic                        cs_n,
    output logic                        sclk,
    output logic                        mosi,
    input  logic                        miso
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FRAME, S_GAP, S_FINISH} state_t;
    typedef enum logic [1:0] {JOB_CFG, JOB_REC, JOB_ZCK} job_t;

    localparam logic [6:0] LAST_CFG  = 7'(N_CFG - 1);
    localparam logic [6:0] LAST_REC  = 7'(CHANNELS + 1);
    localparam logic [6:0] LAST_ZCK  = 7'(ZCHECK_SAMPLES + 4);
    localparam logic [6:0] ZCK_DUMMY = 7'(ZCHECK_SAMPLES + 2);
    localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

    state_t      state;
    job_t        job;
    logic [6:0]  frame;
    logic [4:0]  phase;
    logic [7:0]  gap_cnt;
    logic [15:0] word;
    logic [15:0] rx;
    logic [5:0]  ch;
    logic [1:0]  scale;

    logic [15:0] cmd;
    logic [7:0]  cfg_byte;
    logic [6:0]  last_frame;
    logic [4:0]  phase_next;

    assign phase_next = phase + 5'd1;

    always_comb begin
        cfg_byte = 8'h00;
        for (int i = 0; i < N_CFG; i++) begin
            if (frame == 7'(i)) cfg_byte = cfg_data[8*i +: 8];
        end
    end

    // Command word for the current frame index of the active job.
    always_comb begin
        cmd        = 16'h0000;
        last_frame = LAST_CFG;
        case (job)
            JOB_CFG: begin
                cmd        = {2'b10, frame[5:0], cfg_byte};
                last_frame = LAST_CFG;
            end
            JOB_REC: begin
                cmd        = (frame < 7'(CHANNELS)) ? {2'b00, frame[5:0], 8'h00}
                                                    : {2'b00, 6'h3f, 8'h00};
                last_frame = LAST_REC;
            end
            JOB_ZCK: begin
                if (frame == 7'd0)
                    cmd = {2'b10, 6'd7, 2'b00, ch};
                else if (frame == 7'd1)
                    cmd = {2'b10, 6'd5, 4'b0000, scale, 2'b01};
                else if (frame < ZCK_DUMMY)
                    cmd = {2'b00, ch, 8'h00};
                else if (frame < LAST_ZCK)
                    cmd = {2'b00, 6'h3f, 8'h00};
                else
                    cmd = {2'b10, 6'd5, 8'h00};
                last_frame = LAST_ZCK;
            end
            default: begin
                cmd        = 16'h0000;
                last_frame = LAST_CFG;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= S_IDLE;
            job             <= JOB_CFG;
            frame           <= 7'd0;
            phase           <= 5'd0;
            gap_cnt         <= 8'd0;
            word            <= 16'h0000;
            rx              <= 16'h0000;
            ch              <= 6'd0;
            scale           <= 2'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            zcheck_error    <= 1'b0;
            data_out        <= '0;
            zcheck_data_out <= '0;
            channel_out     <= 8'd0;
            cs_n            <= 1'b1;
            sclk            <= 1'b0;
            mosi            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    frame <= 7'd0;
                    if (config_start) begin
                        job   <= JOB_CFG;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end else if (zcheck_start) begin
                        job   <= JOB_ZCK;
                        ch    <= zcheck_channel[5:0];
                        scale <= zcheck_scale;
                        busy  <= 1'b1;
                        if (zcheck_channel >= 12'(CHANNELS)) begin
                            zcheck_error <= 1'b1;
                            state        <= S_FINISH;
                        end else begin
                            zcheck_error <= 1'b0;
                            state        <= S_LOAD;
                        end
                    end else if (record_start) begin
                        job   <= JOB_REC;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    word  <= cmd;
                    mosi  <= cmd[15];
                    cs_n  <= 1'b0;
                    sclk  <= 1'b0;
                    phase <= 5'd0;
                    state <= S_FRAME;
                end
                S_FRAME: begin
                    if (phase[0]) rx <= {rx[14:0], miso};
                    if (phase == 5'd31) begin
                        cs_n    <= 1'b1;
                        sclk    <= 1'b0;
                        mosi    <= 1'b0;
                        gap_cnt <= 8'd0;
                        state   <= S_GAP;
                    end else begin
                        phase <= phase_next;
                        sclk  <= phase_next[0];
                        mosi  <= word[~phase_next[4:1]];
                    end
                end
                S_GAP: begin
                    // Results trail their CONVERT by two frames of chip pipeline.
                    if (gap_cnt == 8'd0) begin
                        if (job == JOB_REC) begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                if (frame == 7'(c + 2)) data_out[16*c +: 16] <= rx;
                            end
                            if (frame >= 7'd2) channel_out <= {1'b0, frame - 7'd2};
                        end else if (job == JOB_ZCK) begin
                            for (int s = 0; s < ZCHECK_SAMPLES; s++) begin
                                if (frame == 7'(s + 4)) zcheck_data_out[16*s +: 16] <= rx;
                            end
                        end
                    end
                    if (gap_cnt == GAP_LAST) begin
                        if (frame == last_frame) begin
                            state <= S_FINISH;
                        end else begin
                            frame <= frame + 7'd1;
                            state <= S_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
